qpi_seq_ctrl: RTL and testbench

Transaction sequencer for the 2x-clocked iCE40 QPI PHY. It accepts one command request at a time and drives the PHY's byte-wide interface cycle by cycle through these phases: chip select, command byte, optional 24-bit address, dummy cycles, and write or read data. It performs the nibble interleave the PHY expects, stalls the serial clock when write data is late, and realigns captured read data. It sits between the QPI memory controller front-end (wishbone/cache side) and the PHY.

---
 rtl/qpi_seq_ctrl.sv | 149 ++++++++++++++
 tb/tb_qpi_seq_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/qpi_seq_ctrl.sv
// qpi_seq_ctrl: sequences cmd/addr/dummy/data phases onto the 2x-clocked iCE40 QPI PHY,
// stalling SCK on late write data and realigning captured read bytes.
module qpi_seq_ctrl #(
    parameter int N_CS         = 2,
    parameter int LEN_WIDTH    = 8,
    parameter int PHY_RD_DELAY = 3,
    parameter int CS_HOLD      = 2,
    parameter int CS_IDLE      = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [7:0]           req_cmd,
    input  logic [23:0]          req_addr,
    input  logic                 req_has_addr,
    input  logic [3:0]           req_dummy,
    input  logic                 req_write,
    input  logic [LEN_WIDTH-1:0] req_len,
    input  logic [N_CS-1:0]      req_cs_sel,
    input  logic [7:0]           wdata,
    input  logic                 wvalid,
    output logic                 wready,
    output logic [7:0]           rdata,
    output logic                 rvalid,
    output logic                 rlast,
    output logic                 done,
    output logic [7:0]           phy_io_o,
    output logic [3:0]           phy_io_oe,
    input  logic [7:0]           phy_io_i,
    output logic [1:0]           phy_clk_o,
    output logic [N_CS-1:0]      phy_cs_o
);
    localparam int HOLD_LEN = CS_HOLD > PHY_RD_DELAY ? CS_HOLD : PHY_RD_DELAY;

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, HOLD, GAP} state_t;

    state_t                state, after_hdr;
    logic [7:0]            cmd_q, io_q, cnt, hdr_cnt, out_byte;
    logic [23:0]           addr_q;
    logic                  has_addr_q, wr_q, rd_act, wr_act, last_byte;
    logic [3:0]            dummy_q;
    logic [LEN_WIDTH-1:0]  len_q, len_cnt;
    logic [N_CS-1:0]       cs_q;
    logic [PHY_RD_DELAY-1:0] tag, last_tag;

    function automatic logic [7:0] swz(input logic [7:0] b);
        return {b[7], b[3], b[6], b[2], b[5], b[1], b[4], b[0]};
    endfunction

    function automatic logic [7:0] deswz(input logic [7:0] i);
        return {i[7], i[5], i[3], i[1], i[6], i[4], i[2], i[0]};
    endfunction

    always_comb begin
        rd_act    = state == DATA && !wr_q;
        wr_act    = state == DATA && wr_q && wvalid;
        last_byte = len_cnt == LEN_WIDTH'(1);
        after_hdr = dummy_q != 4'd0 ? DUMMY : len_q != '0 ? DATA : HOLD;
        hdr_cnt   = dummy_q != 4'd0 ? {4'd0, dummy_q - 4'd1} : 8'(HOLD_LEN - 1);
        out_byte  = state == CMD ? cmd_q : state == ADDR ? addr_q[23:16] : wdata;
        // a stalled write cycle keeps the previous byte on the pads
        phy_io_o  = (state == CMD || state == ADDR || wr_act) ? swz(out_byte) :
                    (state == DATA && wr_q) ? io_q : 8'h00;
        phy_io_oe = (state == CMD || state == ADDR || (state == DATA && wr_q)) ? 4'hF : 4'h0;
        phy_clk_o = {1'b0, state == CMD || state == ADDR || state == DUMMY || rd_act || wr_act};
        phy_cs_o  = (state == IDLE || state == GAP) ? '1 : ~cs_q;
        wready    = state == DATA && wr_q;
        done      = state == GAP && cnt == 8'd0;
        rvalid    = tag[PHY_RD_DELAY-1];
        rlast     = last_tag[PHY_RD_DELAY-1];
        rdata     = rvalid ? deswz(phy_io_i) : 8'h00;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            req_ready <= 1'b0;
            cnt       <= '0;
            len_cnt   <= '0;
            io_q      <= '0;
            tag       <= '0;
            last_tag  <= '0;
        end else begin
            io_q     <= phy_io_o;
            tag      <= (tag << 1) | PHY_RD_DELAY'(rd_act);
            last_tag <= (last_tag << 1) | PHY_RD_DELAY'(rd_act && last_byte);
            case (state)
                IDLE: begin
                    req_ready <= !(req_valid && req_ready);
                    if (req_valid && req_ready) begin
                        state      <= CMD;
                        cmd_q      <= req_cmd;
                        addr_q     <= req_addr;
                        has_addr_q <= req_has_addr;
                        dummy_q    <= req_dummy;
                        wr_q       <= req_write;
                        len_q      <= req_len;
                        len_cnt    <= req_len;
                        cs_q       <= req_cs_sel;
                    end
                end
                CMD: begin
                    state <= has_addr_q ? ADDR : after_hdr;
                    cnt   <= has_addr_q ? 8'd2 : hdr_cnt;
                end
                ADDR: begin
                    addr_q <= addr_q << 8;
                    cnt    <= cnt - 8'd1;
                    if (cnt == 8'd0) begin
                        state <= after_hdr;
                        cnt   <= hdr_cnt;
                    end
                end
                DUMMY: begin
                    cnt <= cnt - 8'd1;
                    if (cnt == 8'd0) begin
                        state <= len_q != '0 ? DATA : HOLD;
                        cnt   <= 8'(HOLD_LEN - 1);
                    end
                end
                DATA: begin
                    if (rd_act || wr_act) begin
                        len_cnt <= len_cnt - LEN_WIDTH'(1);
                        if (last_byte) begin
                            state <= HOLD;
                            cnt   <= 8'(HOLD_LEN - 1);
                        end
                    end
                end
                HOLD: begin
                    cnt <= cnt - 8'd1;
                    if (cnt == 8'd0) begin
                        state <= GAP;
                        cnt   <= 8'(CS_IDLE - 1);
                    end
                end
                GAP: begin
                    cnt <= cnt - 8'd1;
                    if (cnt == 8'd0) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_qpi_seq_ctrl.sv
// tb_qpi_seq_ctrl: scoreboard bench; stimulus pushes expected PHY cycles, stall cycles
// and read bytes into queues, a negedge monitor pops and compares them.
module tb_qpi_seq_ctrl;
    localparam int RD = 3;
    localparam logic [20:0] RST = {5'b0, 2'b11, 4'h0, 8'h00, 2'b00};

    logic        clk = 0, rst_n = 0;
    logic        req_valid = 0, req_has_addr = 0, req_write = 0;
    logic        req_ready;
    logic [7:0]  req_cmd = 0, req_len = 0;
    logic [23:0] req_addr = 0;
    logic [3:0]  req_dummy = 0;
    logic [1:0]  req_cs_sel = 0;
    logic [7:0]  wdata = 0;
    logic        wvalid = 0, wready;
    logic [7:0]  rdata;
    logic        rvalid, rlast, done;
    logic [7:0]  phy_io_o, phy_io_i = 8'hFF;
    logic [3:0]  phy_io_oe;
    logic [1:0]  phy_clk_o, phy_cs_o;

    qpi_seq_ctrl #(.N_CS(2), .LEN_WIDTH(8), .PHY_RD_DELAY(RD), .CS_HOLD(2), .CS_IDLE(2)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_cmd(req_cmd), .req_addr(req_addr), .req_has_addr(req_has_addr),
        .req_dummy(req_dummy), .req_write(req_write), .req_len(req_len),
        .req_cs_sel(req_cs_sel), .wdata(wdata), .wvalid(wvalid), .wready(wready),
        .rdata(rdata), .rvalid(rvalid), .rlast(rlast), .done(done),
        .phy_io_o(phy_io_o), .phy_io_oe(phy_io_oe), .phy_io_i(phy_io_i),
        .phy_clk_o(phy_clk_o), .phy_cs_o(phy_cs_o)
    );

    int n_chk = 0, n_pass = 0, cyc = 0, n_done = 0, n_wr = 0, n_rd = 0;
    int hi_run = 0, lo_run = 0, last_gap = 0, last_lo = 0;
    int d0, w0, r0, acc_cyc, acc_a, t;
    bit mon_en = 0, cs_both = 0;
    logic [15:0] exp_io[$], exp_stall[$];
    logic [8:0]  exp_rd[$], rd_src[$], wsched[$];
    logic [8:0]  src_e;
    logic [7:0]  rsp[int];

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected summary");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    task automatic miss(input string nm, input logic [31:0] act);
        n_chk++;
        $display("FAIL %s: got %0h, expected nothing", nm, act);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void act(input logic [1:0] cs, input logic [3:0] oe, input logic [7:0] io);
        exp_io.push_back({cs, oe, io, 2'b01});
    endfunction

    function automatic logic [20:0] outs();
        return {req_ready, wready, rvalid, rlast, done, phy_cs_o, phy_io_oe, phy_io_o, phy_clk_o};
    endfunction

    task automatic send(input logic [7:0] c, input logic [23:0] a, input logic ha, input logic [3:0] dm,
                        input logic wr, input logic [7:0] ln, input logic [1:0] cs);
        req_cmd = c; req_addr = a; req_has_addr = ha; req_dummy = dm;
        req_write = wr; req_len = ln; req_cs_sel = cs; req_valid = 1;
        for (int i = 0; i < 100 && !req_ready; i++) step();
        check("req_accept", 32'(req_ready), 32'd1);
        acc_cyc = cyc;
        step();
        req_valid = 0;
    endtask

    task automatic wait_done(input string nm, input int target);
        for (int i = 0; i < 200 && n_done < target; i++) step();
        check(nm, n_done, target);
    endtask

    // write-data source: one schedule entry per DATA cycle
    initial forever begin
        @(posedge clk);
        #1;
        if (wready && wsched.size() != 0) {wvalid, wdata} = wsched.pop_front();
        else begin
            wvalid = 0;
            wdata = 8'h00;
        end
    end

    // read responder: drives the captured byte RD cycles after its active cycle
    initial forever begin
        @(posedge clk);
        #1;
        phy_io_i = rsp.exists(cyc) ? rsp[cyc] : 8'hFF;
    end

    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            if (phy_clk_o != 2'b00) begin
                if (exp_io.size() == 0) miss("phy_cycle", 32'({phy_cs_o, phy_io_oe, phy_io_o, phy_clk_o}));
                else check("phy_cycle", 32'({phy_cs_o, phy_io_oe, phy_io_o, phy_clk_o}), 32'(exp_io.pop_front()));
                if (phy_io_oe == 4'h0 && !wready && rd_src.size() != 0) begin
                    src_e = rd_src.pop_front();
                    if (src_e[8]) rsp[cyc + RD] = src_e[7:0];
                end
            end
            if (wready && !wvalid) begin
                if (exp_stall.size() == 0) miss("stall_cycle", 32'({phy_cs_o, phy_io_oe, phy_io_o, phy_clk_o}));
                else check("stall_cycle", 32'({phy_cs_o, phy_io_oe, phy_io_o, phy_clk_o}), 32'(exp_stall.pop_front()));
            end
            if (wready && wvalid) n_wr++;
            if (rvalid) begin
                n_rd++;
                if (exp_rd.size() == 0) miss("rd_byte", 32'({rlast, rdata}));
                else check("rd_byte", 32'({rlast, rdata}), 32'(exp_rd.pop_front()));
            end
            if (done) n_done++;
            if (phy_cs_o == 2'b00) cs_both = 1;
            if (&phy_cs_o) begin
                if (lo_run != 0) begin
                    last_lo = lo_run;
                    lo_run = 0;
                end
                hi_run++;
            end else begin
                if (hi_run != 0) begin
                    last_gap = hi_run;
                    hi_run = 0;
                end
                lo_run++;
            end
        end
    end

    initial begin
        repeat (3) step();
        check("rst_outputs", 32'(outs()), 32'(RST));
        rst_n = 1;
        step();
        check("ready_after_rst", 32'(req_ready), 32'd1);
        mon_en = 1;

        d0 = n_done; w0 = n_wr;
        act(2'b10, 4'hF, 8'h4A); act(2'b10, 4'hF, 8'h06); act(2'b10, 4'hF, 8'h1A);
        act(2'b10, 4'hF, 8'h36); act(2'b10, 4'hF, 8'h99); act(2'b10, 4'hF, 8'h5A);
        wsched.push_back({1'b1, 8'hA5}); wsched.push_back({1'b1, 8'h3C});
        send(8'h38, 24'h123456, 1'b1, 4'd0, 1'b1, 8'd2, 2'b01);
        wait_done("wr_done", d0 + 1);
        check("wr_io_left", exp_io.size(), 0);
        check("wr_bytes", n_wr - w0, 2);
        check("wr_cs_low", last_lo, 9);

        d0 = n_done;
        act(2'b10, 4'hF, 8'hED); act(2'b10, 4'hF, 8'h00); act(2'b10, 4'hF, 8'h01); act(2'b10, 4'hF, 8'h00);
        repeat (7) act(2'b10, 4'h0, 8'h00);
        repeat (3) rd_src.push_back(9'h000);
        rd_src.push_back({1'b1, 8'h03}); rd_src.push_back({1'b1, 8'h0C});
        rd_src.push_back({1'b1, 8'h0F}); rd_src.push_back({1'b1, 8'h30});
        exp_rd.push_back({1'b0, 8'h11}); exp_rd.push_back({1'b0, 8'h22});
        exp_rd.push_back({1'b0, 8'h33}); exp_rd.push_back({1'b1, 8'h44});
        send(8'hEB, 24'h000100, 1'b1, 4'd3, 1'b0, 8'd4, 2'b01);
        wait_done("rd_done", d0 + 1);
        check("rd_left", exp_rd.size(), 0);
        check("rd_io_left", exp_io.size(), 0);

        d0 = n_done; w0 = n_wr;
        act(2'b10, 4'hF, 8'h4A);
        repeat (3) act(2'b10, 4'hF, 8'h00);
        act(2'b10, 4'hF, 8'h06); act(2'b10, 4'hF, 8'h1A); act(2'b10, 4'hF, 8'h36);
        wsched.push_back({1'b1, 8'h12});
        repeat (3) wsched.push_back({1'b0, 8'hEE});
        wsched.push_back({1'b1, 8'h34}); wsched.push_back({1'b1, 8'h56});
        repeat (3) exp_stall.push_back({2'b10, 4'hF, 8'h06, 2'b00});
        send(8'h38, 24'h000000, 1'b1, 4'd0, 1'b1, 8'd3, 2'b01);
        wait_done("stall_done", d0 + 1);
        check("stall_left", exp_stall.size(), 0);
        check("stall_io_left", exp_io.size(), 0);
        check("stall_bytes", n_wr - w0, 3);
        check("stall_cs_low", last_lo, 13);

        d0 = n_done;
        act(2'b10, 4'hF, 8'h3C);
        send(8'h66, 24'h000000, 1'b0, 4'd0, 1'b0, 8'd0, 2'b01);
        t = 1;
        while (!req_ready && t < 50) begin
            step();
            t++;
        end
        check("op_ready_cycles", t, 7);
        wait_done("op_done", d0 + 1);
        check("op_io_left", exp_io.size(), 0);
        check("op_cs_low", last_lo, 4);

        d0 = n_done; cs_both = 0;
        act(2'b10, 4'hF, 8'h3C);
        act(2'b01, 4'hF, 8'hC3); act(2'b01, 4'hF, 8'h99); act(2'b01, 4'hF, 8'h5A); act(2'b01, 4'hF, 8'h06);
        send(8'h66, 24'h000000, 1'b0, 4'd0, 1'b0, 8'd0, 2'b01);
        acc_a = acc_cyc;
        send(8'h99, 24'hA53C12, 1'b1, 4'd0, 1'b0, 8'd0, 2'b10);
        check("b2b_spacing", acc_cyc - acc_a, 7);
        wait_done("b2b_done", d0 + 2);
        check("b2b_cs_excl", 32'(cs_both), 32'd0);
        check("b2b_cs_gap", 32'(last_gap >= 2), 32'd1);
        check("b2b_io_left", exp_io.size(), 0);

        r0 = n_rd;
        act(2'b10, 4'hF, 8'h45);
        repeat (8) act(2'b10, 4'h0, 8'h00);
        repeat (2) begin
            rd_src.push_back({1'b1, 8'h03}); rd_src.push_back({1'b1, 8'h0C});
            rd_src.push_back({1'b1, 8'h0F}); rd_src.push_back({1'b1, 8'h30});
        end
        repeat (2) begin
            exp_rd.push_back({1'b0, 8'h11}); exp_rd.push_back({1'b0, 8'h22});
            exp_rd.push_back({1'b0, 8'h33}); exp_rd.push_back({1'b0, 8'h44});
        end
        send(8'h0B, 24'h000000, 1'b0, 4'd0, 1'b0, 8'd8, 2'b01);
        for (int i = 0; i < 50 && n_rd == r0; i++) step();
        check("rs_first_rd", n_rd - r0, 1);
        rst_n = 0; mon_en = 0; d0 = n_done;
        step();
        check("rs_outputs", 32'(outs()), 32'(RST));
        exp_io.delete(); exp_rd.delete(); rd_src.delete(); wsched.delete();
        rst_n = 1; mon_en = 1;
        step();
        check("rs_ready", 32'(req_ready), 32'd1);
        repeat (10) step();
        check("rs_no_done", n_done, d0);
        act(2'b01, 4'hF, 8'h3C);
        send(8'h66, 24'h000000, 1'b0, 4'd0, 1'b0, 8'd0, 2'b10);
        wait_done("rs_next_done", d0 + 1);
        check("rs_io_left", exp_io.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
